rv32i_control_unit: RTL and testbench
=====================================

// Module: rv32i_control_unit
// PURPOSE
//  Main decoder of the RV32I single-issue core. Maps opcode, funct3 and instr[30]
//  onto datapath controls: ALU op, next-PC select, immediate type, operand muxes,
//  memory and write-back enables. Outputs are registered, so they are valid
//  one cycle after the instruction fields are presented.
// PARAMETERS
//  none (all encodings fixed below)
// PORTS
//  clk        in   1  clock; all outputs update on the rising edge
//  rst        in   1  reset, asynchronous, active-high
//  opcode     in   7  instr[6:0]
//  fun3       in   3  instr[14:12]
//  func7      in   1  instr[30]
//  ALU_C      out  4  ALU operation code
//  N_PC       out  2  next-PC select
//  IMM_sel    out  2  immediate-format select
//  OP_A       out  2  ALU operand-A select
//  OP_B       out  1  ALU operand-B select: 0=rs2, 1=immediate
//  Mem2Reg    out  1  write-back source: 1=load data, 0=ALU result
//  load       out  1  data-memory read enable
//  store      out  1  data-memory write enable
//  branch     out  1  conditional branch; datapath evaluates fun3 compare
//  reg_write  out  1  register-file write enable
// BEHAVIOUR
//  - Asynchronous reset (rst=1): every output is 0 immediately and held there.
//  - Otherwise outputs register the combinational decode of the current inputs.
//    Latency is 1 clock. No handshake.
//  - ALU_C encodings:
//    0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR,
//    0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B, 1011 A_PLUS_4.
//  - N_PC: 00 PC+4, 01 branch target if taken, 10 PC+imm (JAL), 11 rs1+imm (JALR).
//  - IMM_sel: 00 I, 01 S, 10 B, 11 U/J.
//    In the 11 case the immediate unit selects J when opcode[3]=1, U otherwise.
//  - OP_A: 00 rs1, 01 PC, 10 zero. The value 11 is never driven.
//  - R 0110011: reg_write=1, OP_B=0, IMM_sel=00.
//    ALU decoded from fun3 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR,
//    101 SRL/SRA, 110 OR, 111 AND.
//    func7=1 selects SUB (fun3 000) or SRA (fun3 101) and is ignored for the other fun3 values.
//  - I-ALU 0010011: same fun3 map with OP_B=1, IMM_sel=00, reg_write=1.
//    fun3 000 is always ADD, regardless of func7. func7 is honoured only for fun3 101 (SRAI).
//  - LOAD 0000011: load=1, Mem2Reg=1, reg_write=1, OP_B=1, IMM_sel=00, ALU ADD.
//  - STORE 0100011: store=1, OP_B=1, IMM_sel=01, ALU ADD, reg_write=0.
//  - BRANCH 1100011: branch=1, N_PC=01, IMM_sel=10, OP_B=0, ALU SUB, reg_write=0.
//  - JAL 1101111: N_PC=10, IMM_sel=11, OP_A=01, ALU A_PLUS_4, reg_write=1.
//  - JALR 1100111: N_PC=11, IMM_sel=00, OP_A=01, ALU A_PLUS_4, reg_write=1.
//  - LUI 0110111: OP_A=10, OP_B=1, IMM_sel=11, ALU ADD, reg_write=1.
//  - AUIPC 0010111: OP_A=01, OP_B=1, IMM_sel=11, ALU ADD, reg_write=1.
//  - Every field not listed for an opcode is 0. FENCE, SYSTEM and any undefined
//    opcode decode as a NOP (all outputs 0, i.e. N_PC=PC+4, no writes).
//  - load, store and branch are mutually exclusive, so at most one is 1.
//  - Reset asserted mid-stream: outputs go to 0 at once. The first decode
//    appears on the first rising edge after rst is released.
// TESTING
//  1. rst=1, apply random inputs -> all outputs 0 with no clock edge.
//     Release rst -> next edge shows the decode.
//  2. op=0110011, fun3=000, func7=1 -> after 1 edge: ALU_C=0001, reg_write=1,
//     OP_B=0, OP_A=00, N_PC=00, load=store=branch=0.
//     Then func7=0 -> ALU_C=0000.
//  3. op=1101111 -> N_PC=10, IMM_sel=11, OP_A=01, ALU_C=1011, reg_write=1, Mem2Reg=0.
//  4. op=0000011 (load) -> load=1, Mem2Reg=1, OP_B=1, ALU_C=0000.
//     op=0100011 (store) -> store=1, IMM_sel=01, reg_write=0.
//  5. op=1100011 (branch), fun3=001 -> branch=1, N_PC=01, IMM_sel=10, ALU_C=0001, reg_write=0.
//  6. op=0010011, fun3=101, func7=1 -> ALU_C=0111.
//     fun3=000, func7=1 -> ALU_C=0000.
//     op=1111111 -> all outputs 0.

Source files
------------

// File: rtl/rv32i_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_control_unit
// Description : Main decoder of the RV32I single-issue core. Turns opcode,
//               funct3 and instr[30] into registered datapath controls, so
//               every control is valid one clock after the instruction fields
//               are presented. rst clears every output immediately.
// Ports       : clk       - clock, outputs update on the rising edge
//               rst       - asynchronous active-high reset
//               opcode    - instr[6:0]
//               fun3      - instr[14:12]
//               func7     - instr[30]
//               ALU_C     - ALU operation code
//               N_PC      - next-PC select (PC+4 / branch / JAL / JALR)
//               IMM_sel   - immediate format (I / S / B / U-or-J)
//               OP_A      - ALU operand A select (rs1 / PC / zero)
//               OP_B      - ALU operand B select (rs2 / immediate)
//               Mem2Reg   - write-back source (load data / ALU result)
//               load      - data-memory read enable
//               store     - data-memory write enable
//               branch    - conditional branch, compare chosen by fun3
//               reg_write - register-file write enable
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] fun3,
    input  logic       func7,
    output logic [3:0] ALU_C,
    output logic [1:0] N_PC,
    output logic [1:0] IMM_sel,
    output logic [1:0] OP_A,
    output logic       OP_B,
    output logic       Mem2Reg,
    output logic       load,
    output logic       store,
    output logic       branch,
    output logic       reg_write
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    // ------------------------------------------------------------------
    // ALU operation codes
    // ------------------------------------------------------------------
    localparam logic [3:0] c_ALU_ADD      = 4'b0000;
    localparam logic [3:0] c_ALU_SUB      = 4'b0001;
    localparam logic [3:0] c_ALU_SLL      = 4'b0010;
    localparam logic [3:0] c_ALU_SLT      = 4'b0011;
    localparam logic [3:0] c_ALU_SLTU     = 4'b0100;
    localparam logic [3:0] c_ALU_XOR      = 4'b0101;
    localparam logic [3:0] c_ALU_SRL      = 4'b0110;
    localparam logic [3:0] c_ALU_SRA      = 4'b0111;
    localparam logic [3:0] c_ALU_OR       = 4'b1000;
    localparam logic [3:0] c_ALU_AND      = 4'b1001;
    localparam logic [3:0] c_ALU_A_PLUS_4 = 4'b1011;

    // ------------------------------------------------------------------
    // Select encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] c_NPC_PC4    = 2'b00;
    localparam logic [1:0] c_NPC_BRANCH = 2'b01;
    localparam logic [1:0] c_NPC_JAL    = 2'b10;
    localparam logic [1:0] c_NPC_JALR   = 2'b11;

    localparam logic [1:0] c_IMM_I  = 2'b00;
    localparam logic [1:0] c_IMM_S  = 2'b01;
    localparam logic [1:0] c_IMM_B  = 2'b10;
    localparam logic [1:0] c_IMM_UJ = 2'b11;

    localparam logic [1:0] c_OPA_RS1  = 2'b00;
    localparam logic [1:0] c_OPA_PC   = 2'b01;
    localparam logic [1:0] c_OPA_ZERO = 2'b10;

    // ------------------------------------------------------------------
    // Arithmetic funct3 map shared by register and immediate forms.
    // instr[30] picks SUB only for the register form: in the immediate
    // form that bit belongs to the immediate, so ADDI must ignore it.
    // SRA/SRAI are the only shift variants that honour it in both forms.
    // ------------------------------------------------------------------
    function automatic logic [3:0] alu_from_fun3(
        input logic [2:0] f3,
        input logic       f7,
        input logic       is_reg
    );
        logic [3:0] op;
        op = c_ALU_ADD;
        case (f3)
            3'b000:  op = (is_reg && f7) ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = f7 ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            3'b111:  op = c_ALU_AND;
            default: op = c_ALU_ADD;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [3:0] w_alu_c;
    logic [1:0] w_n_pc;
    logic [1:0] w_imm_sel;
    logic [1:0] w_op_a;
    logic       w_op_b;
    logic       w_mem2reg;
    logic       w_load;
    logic       w_store;
    logic       w_branch;
    logic       w_reg_write;

    always_comb begin
        // Defaults form the NOP decode: FENCE, SYSTEM and unknown opcodes
        // fall through with no writes and sequential PC.
        w_alu_c     = c_ALU_ADD;
        w_n_pc      = c_NPC_PC4;
        w_imm_sel   = c_IMM_I;
        w_op_a      = c_OPA_RS1;
        w_op_b      = 1'b0;
        w_mem2reg   = 1'b0;
        w_load      = 1'b0;
        w_store     = 1'b0;
        w_branch    = 1'b0;
        w_reg_write = 1'b0;

        case (opcode)
            c_OP_R: begin
                w_alu_c     = alu_from_fun3(fun3, func7, 1'b1);
                w_reg_write = 1'b1;
            end
            c_OP_I_ALU: begin
                w_alu_c     = alu_from_fun3(fun3, func7, 1'b0);
                w_op_b      = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_LOAD: begin
                w_alu_c     = c_ALU_ADD;
                w_op_b      = 1'b1;
                w_load      = 1'b1;
                w_mem2reg   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_STORE: begin
                w_alu_c   = c_ALU_ADD;
                w_op_b    = 1'b1;
                w_imm_sel = c_IMM_S;
                w_store   = 1'b1;
            end
            c_OP_BRANCH: begin
                // ALU subtracts so the datapath can derive the compare
                // flags; the actual condition is chosen from fun3 there.
                w_alu_c   = c_ALU_SUB;
                w_n_pc    = c_NPC_BRANCH;
                w_imm_sel = c_IMM_B;
                w_branch  = 1'b1;
            end
            c_OP_JAL: begin
                // ALU computes the link value PC+4; the jump target is
                // formed by the next-PC adder.
                w_alu_c     = c_ALU_A_PLUS_4;
                w_n_pc      = c_NPC_JAL;
                w_imm_sel   = c_IMM_UJ;
                w_op_a      = c_OPA_PC;
                w_reg_write = 1'b1;
            end
            c_OP_JALR: begin
                w_alu_c     = c_ALU_A_PLUS_4;
                w_n_pc      = c_NPC_JALR;
                w_imm_sel   = c_IMM_I;
                w_op_a      = c_OPA_PC;
                w_reg_write = 1'b1;
            end
            c_OP_LUI: begin
                // zero + U-immediate
                w_alu_c     = c_ALU_ADD;
                w_op_a      = c_OPA_ZERO;
                w_op_b      = 1'b1;
                w_imm_sel   = c_IMM_UJ;
                w_reg_write = 1'b1;
            end
            c_OP_AUIPC: begin
                w_alu_c     = c_ALU_ADD;
                w_op_a      = c_OPA_PC;
                w_op_b      = 1'b1;
                w_imm_sel   = c_IMM_UJ;
                w_reg_write = 1'b1;
            end
            default: begin
                w_alu_c = c_ALU_ADD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [3:0] r_alu_c;
    logic [1:0] r_n_pc;
    logic [1:0] r_imm_sel;
    logic [1:0] r_op_a;
    logic       r_op_b;
    logic       r_mem2reg;
    logic       r_load;
    logic       r_store;
    logic       r_branch;
    logic       r_reg_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_c     <= 4'b0000;
            r_n_pc      <= 2'b00;
            r_imm_sel   <= 2'b00;
            r_op_a      <= 2'b00;
            r_op_b      <= 1'b0;
            r_mem2reg   <= 1'b0;
            r_load      <= 1'b0;
            r_store     <= 1'b0;
            r_branch    <= 1'b0;
            r_reg_write <= 1'b0;
        end else begin
            r_alu_c     <= w_alu_c;
            r_n_pc      <= w_n_pc;
            r_imm_sel   <= w_imm_sel;
            r_op_a      <= w_op_a;
            r_op_b      <= w_op_b;
            r_mem2reg   <= w_mem2reg;
            r_load      <= w_load;
            r_store     <= w_store;
            r_branch    <= w_branch;
            r_reg_write <= w_reg_write;
        end
    end

    assign ALU_C     = r_alu_c;
    assign N_PC      = r_n_pc;
    assign IMM_sel   = r_imm_sel;
    assign OP_A      = r_op_a;
    assign OP_B      = r_op_b;
    assign Mem2Reg   = r_mem2reg;
    assign load      = r_load;
    assign store     = r_store;
    assign branch    = r_branch;
    assign reg_write = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_control_unit
// Description : Scoreboard bench for rv32i_control_unit. Directed vectors are
//               driven on the falling edge with their hand-computed controls
//               queued; a monitor pops one entry after each rising edge and
//               compares. Reset behaviour is checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_control_unit;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] npc;
        logic [1:0] imm;
        logic [1:0] opa;
        logic       opb;
        logic       m2r;
        logic       ld;
        logic       st;
        logic       br;
        logic       rw;
    } ctl_t;

    typedef struct {
        ctl_t  exp;
        string name;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] fun3 = 3'd0;
    logic       func7 = 1'b0;
    logic [3:0] ALU_C;
    logic [1:0] N_PC;
    logic [1:0] IMM_sel;
    logic [1:0] OP_A;
    logic       OP_B;
    logic       Mem2Reg;
    logic       load;
    logic       store;
    logic       branch;
    logic       reg_write;

    int         n_compared = 0;
    int         n_failed   = 0;
    sb_entry_t  sb_q[$];

    rv32i_control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .fun3      (fun3),
        .func7     (func7),
        .ALU_C     (ALU_C),
        .N_PC      (N_PC),
        .IMM_sel   (IMM_sel),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .Mem2Reg   (Mem2Reg),
        .load      (load),
        .store     (store),
        .branch    (branch),
        .reg_write (reg_write)
    );

    always #5 clk = ~clk;

    function automatic ctl_t mk(
        input logic [3:0] alu, input logic [1:0] npc, input logic [1:0] imm,
        input logic [1:0] opa, input logic opb, input logic m2r,
        input logic ld, input logic st, input logic br, input logic rw
    );
        ctl_t c;
        c.alu = alu; c.npc = npc; c.imm = imm; c.opa = opa; c.opb = opb;
        c.m2r = m2r; c.ld = ld; c.st = st; c.br = br; c.rw = rw;
        return c;
    endfunction

    function automatic ctl_t actual();
        return mk(ALU_C, N_PC, IMM_sel, OP_A, OP_B, Mem2Reg, load, store, branch, reg_write);
    endfunction

    function automatic void check(input string name, input ctl_t got, input ctl_t exp);
        n_compared++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got alu=%b npc=%b imm=%b opa=%b opb=%b m2r=%b ld=%b st=%b br=%b rw=%b, expected alu=%b npc=%b imm=%b opa=%b opb=%b m2r=%b ld=%b st=%b br=%b rw=%b",
                     name, got.alu, got.npc, got.imm, got.opa, got.opb, got.m2r, got.ld, got.st, got.br, got.rw,
                     exp.alu, exp.npc, exp.imm, exp.opa, exp.opb, exp.m2r, exp.ld, exp.st, exp.br, exp.rw);
        end
    endfunction

    // Monitor: the register captured at this rising edge answers the oldest
    // queued vector.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, actual(), e.exp);
            end
        end
    end

    task automatic drive(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input ctl_t exp);
        sb_entry_t e;
        @(negedge clk);
        opcode = op;
        fun3   = f3;
        func7  = f7;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (sb_q.size() > 0) begin
            n_compared++;
            n_failed++;
            $display("FAIL drain_timeout: got %0d entries pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    localparam ctl_t c_ZERO = '0;

    initial begin
        ctl_t z;
        z = c_ZERO;

        // Reset with arbitrary inputs: outputs clear with no clock edge.
        opcode = 7'($urandom);
        fun3   = 3'($urandom);
        func7  = 1'($urandom);
        #1 rst = 1'b1;
        #2;
        check("reset_async_no_edge", actual(), z);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_over_edges", actual(), z);

        // Release with a load presented; the next edge shows its decode.
        @(negedge clk);
        opcode = 7'b0000011; fun3 = 3'b010; func7 = 1'b0;
        rst = 1'b0;
        sb_q.push_back('{exp: mk(4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 1), name: "first_after_reset_load"});

        // R-type
        drive("r_sub",   7'b0110011, 3'b000, 1, mk(4'b0001, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_add",   7'b0110011, 3'b000, 0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_sll_f7_ignored", 7'b0110011, 3'b001, 1, mk(4'b0010, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_slt",   7'b0110011, 3'b010, 0, mk(4'b0011, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_sltu",  7'b0110011, 3'b011, 0, mk(4'b0100, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_xor",   7'b0110011, 3'b100, 0, mk(4'b0101, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_srl",   7'b0110011, 3'b101, 0, mk(4'b0110, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_sra",   7'b0110011, 3'b101, 1, mk(4'b0111, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_or",    7'b0110011, 3'b110, 0, mk(4'b1000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        drive("r_and_f7_ignored", 7'b0110011, 3'b111, 1, mk(4'b1001, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));

        // Jumps, memory, branch
        drive("jal",     7'b1101111, 3'b000, 0, mk(4'b1011, 2'b10, 2'b11, 2'b01, 0, 0, 0, 0, 0, 1));
        drive("jalr",    7'b1100111, 3'b000, 0, mk(4'b1011, 2'b11, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1));
        drive("load_lw", 7'b0000011, 3'b010, 0, mk(4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 1));
        drive("store_sw",7'b0100011, 3'b010, 0, mk(4'b0000, 2'b00, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0));
        drive("branch_bne", 7'b1100011, 3'b001, 0, mk(4'b0001, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0));

        // I-ALU
        drive("i_srai",  7'b0010011, 3'b101, 1, mk(4'b0111, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1));
        drive("i_addi_f7_ignored", 7'b0010011, 3'b000, 1, mk(4'b0000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1));
        drive("i_slli_f7_ignored", 7'b0010011, 3'b001, 1, mk(4'b0010, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1));
        drive("i_sltiu", 7'b0010011, 3'b011, 0, mk(4'b0100, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1));
        drive("i_andi",  7'b0010011, 3'b111, 0, mk(4'b1001, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1));

        // Upper immediates and NOPs
        drive("lui",     7'b0110111, 3'b000, 0, mk(4'b0000, 2'b00, 2'b11, 2'b10, 1, 0, 0, 0, 0, 1));
        drive("undef_7f",7'b1111111, 3'b111, 1, z);
        drive("fence",   7'b0001111, 3'b000, 0, z);
        drive("system",  7'b1110011, 3'b000, 1, z);
        drive("auipc",   7'b0010111, 3'b000, 0, mk(4'b0000, 2'b00, 2'b11, 2'b01, 1, 0, 0, 0, 0, 1));
        drain();

        // Mid-stream reset while AUIPC decode is on the outputs.
        @(negedge clk);
        opcode = 7'b1101111; fun3 = 3'b000; func7 = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_midstream_immediate", actual(), z);
        @(posedge clk);
        #1;
        check("reset_midstream_held", actual(), z);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{exp: mk(4'b1011, 2'b10, 2'b11, 2'b01, 0, 0, 0, 0, 0, 1), name: "first_after_midstream_reset_jal"});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
`default_nettype wire
